// File: rtl/apb_pkg.sv
// Shared definitions for the APB master arbiter slice.
//  apb_state_e : APB master sequencing states
//  APB_PROT_W  : PPROT width
//  cnt_width() : minimum register width for a counter/pointer over n values
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  localparam int unsigned APB_PROT_W = 3;

  // Width able to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter for the APB master.
//  clk, rst_n : clock, async active-low reset
//  req        : per-requester request vector
//  advance    : grant was taken this cycle; pointer moves past the winner
//  grant      : one-hot grant (all zero when nothing is requested)
// The pointer names the requester with highest priority; it resets to 0.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = cnt_width(NUM_REQ);

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     gidx;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] gnt_dbl;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_gnt;

  // Rotate requests so the pointer lands on bit 0, take the lowest set bit,
  // then rotate the one-hot result back into requester order.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot_req = req_dbl[NUM_REQ-1:0];
    rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
    gnt_dbl = {rot_gnt, rot_gnt} << ptr;
    grant   = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
  end

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Multi-requester APB4 master: round-robin arbitration of NUM_REQ local ports
// onto one APB bus, SETUP/ACCESS sequencing, response return and timeout.
//  PCLK, PRESETn           : APB clock, async active-low reset
//  req_valid/addr/wdata/
//  strb/prot/write         : packed per-requester request fields
//  req_ready               : one-hot combinational accept
//  rsp_valid               : one-hot one-cycle completion pulse
//  rsp_rdata, rsp_slverr   : completion data/error, valid with rsp_valid
//  PSEL..PPROT             : APB master outputs
//  PREADY, PRDATA, PSLVERR : APB slave responses
// TIMEOUT_CYC = 0 disables the timeout.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]         req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]     req_strb,
  input  logic [NUM_REQ*APB_PROT_W-1:0]     req_prot,
  input  logic [NUM_REQ-1:0]                req_write,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_W-1:0]                 rsp_rdata,
  output logic                              rsp_slverr,
  output logic                              PSEL,
  output logic                              PENABLE,
  output logic [ADDR_W-1:0]                 PADDR,
  output logic                              PWRITE,
  output logic [DATA_W-1:0]                 PWDATA,
  output logic [DATA_W/8-1:0]               PSTRB,
  output logic [APB_PROT_W-1:0]             PPROT,
  input  logic                              PREADY,
  input  logic [DATA_W-1:0]                 PRDATA,
  input  logic                              PSLVERR
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  apb_state_e state, state_nxt;

  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    cur_gnt;
  logic                  accept_slot;
  logic                  accept;
  logic                  xfer_done;
  logic                  tmo_hit;
  logic [CNT_W-1:0]      tmo_cnt;

  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [STRB_W-1:0]     sel_strb;
  logic [APB_PROT_W-1:0] sel_prot;
  logic                  sel_write;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Timeout fires on the last allowed ACCESS cycle unless PREADY arrives then.
  always_comb begin
    tmo_hit   = (TIMEOUT_CYC != 0) && (state == APB_ACCESS) && !PREADY &&
                (tmo_cnt == CNT_W'(TMO_LAST));
    xfer_done = (state == APB_ACCESS) && (PREADY || tmo_hit);
  end

  // FSM: state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= APB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      APB_IDLE:   if (|req_valid) state_nxt = APB_SETUP;
      APB_SETUP:  state_nxt = APB_ACCESS;
      APB_ACCESS: if (xfer_done) state_nxt = (|req_valid) ? APB_SETUP : APB_IDLE;
      default:    state_nxt = APB_IDLE;
    endcase
  end

  // FSM: outputs. PSEL/PENABLE come straight from the state register so an
  // asynchronous reset drops them without waiting for a clock.
  always_comb begin
    PSEL        = (state != APB_IDLE);
    PENABLE     = (state == APB_ACCESS);
    accept_slot = (state == APB_IDLE) || xfer_done;
    req_ready   = accept_slot ? grant : '0;
    accept      = |req_ready;
  end

  // Field mux for the current winner.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_prot  = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_strb  = req_strb[i*STRB_W +: STRB_W];
        sel_prot  = req_prot[i*APB_PROT_W +: APB_PROT_W];
        sel_write = req_write[i];
      end
    end
  end

  // APB request registers; cur_gnt remembers the owner of the transfer so the
  // live grant may move freely while the bus is busy.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      PPROT   <= '0;
      cur_gnt <= '0;
    end else if (accept) begin
      PADDR   <= sel_addr;
      PWRITE  <= sel_write;
      PWDATA  <= sel_wdata;
      PSTRB   <= sel_write ? sel_strb : '0;
      PPROT   <= sel_prot;
      cur_gnt <= grant;
    end
  end

  // Timeout counter: cleared in SETUP, counts ACCESS cycles without PREADY.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt <= '0;
    end else if (state == APB_SETUP) begin
      tmo_cnt <= '0;
    end else if ((state == APB_ACCESS) && !PREADY && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Response registers; a timeout reports an error with zero data.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (xfer_done) begin
        rsp_valid  <= cur_gnt;
        rsp_rdata  <= (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_slverr <= PREADY ? PSLVERR : 1'b1;
      end
    end
  end

endmodule
